// File: rtl/alu_seq_pkg.sv
// Opcode constants, FSM state encoding and operand-decode helper shared by the sequencer.
// ALU_SEQ_CHAIN_EN adds opcode 0x03 (chained binary) to the set of operand-carrying opcodes.
package alu_seq_pkg;

  localparam logic [7:0] OP_NOP    = 8'h00;
  localparam logic [7:0] OP_UNARY  = 8'h01;
  localparam logic [7:0] OP_BINARY = 8'h02;
  localparam logic [7:0] OP_CHAIN  = 8'h03;
  localparam logic [7:0] OP_HALT   = 8'hFF;

  typedef enum logic [3:0] {
    IDLE, FETCH, DECODE, LD_OP, LD_A, LD_B, EXEC, HALT, ERR
  } state_e;

  function automatic logic needs_operand(input logic [7:0] opc);
`ifdef ALU_SEQ_CHAIN_EN
    return (opc == OP_UNARY) || (opc == OP_BINARY) || (opc == OP_CHAIN);
`else
    return (opc == OP_UNARY) || (opc == OP_BINARY);
`endif
  endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Bytecode sequencer feeding an external combinational ALU; FETCH to result_valid is 6 cycles binary, 5 unary/chain.
// ALU_SEQ_CHAIN_EN enables opcode 0x03 (op,b with a = previous result); memory answers one cycle after mem_rd, no backpressure.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int MEM_AW     = 10,
  parameter int START_ADDR = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic              mem_rd,
  output logic [MEM_AW-1:0] mem_addr,
  input  logic [7:0]        mem_rdata,
  output logic [5:0]        alu_op,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  input  logic [7:0]        alu_result,
  output logic [7:0]        result,
  output logic              result_valid,
  output logic              running,
  output logic              done,
  output logic              error
);

  localparam logic [MEM_AW-1:0] PC_START = MEM_AW'(START_ADDR);

  state_e            state_q;
  logic [MEM_AW-1:0] pc_q;
  logic [MEM_AW-1:0] pc_d;
  logic [7:0]        opcode_q;
  logic [5:0]        alu_op_q;
  logic [7:0]        alu_a_q;
  logic [7:0]        alu_b_q;
  logic [7:0]        result_q;
  logic              result_valid_q;
  logic              running_q;
  logic              done_q;
  logic              error_q;
  logic              restart;

  assign restart = start && (state_q inside {IDLE, HALT, ERR});

  // The DECODE read depends on the opcode arriving that cycle, so the strobe is decoded, not registered.
  always_comb begin
    mem_rd = 1'b0;
    case (state_q)
      FETCH, LD_OP: mem_rd = 1'b1;
      DECODE:       mem_rd = needs_operand(mem_rdata);
      LD_A:         mem_rd = (opcode_q == OP_BINARY);
      default:      mem_rd = 1'b0;
    endcase
  end

  always_comb begin
    pc_d = pc_q;
    if (restart) begin
      pc_d = PC_START;
    end else if (mem_rd) begin
      pc_d = pc_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      pc_q           <= PC_START;
      opcode_q       <= OP_NOP;
      alu_op_q       <= '0;
      alu_a_q        <= '0;
      alu_b_q        <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      running_q      <= 1'b0;
      done_q         <= 1'b0;
      error_q        <= 1'b0;
    end else begin
      pc_q           <= pc_d;
      result_valid_q <= 1'b0;
      case (state_q)
        IDLE, HALT, ERR: begin
          if (start) begin
            state_q   <= FETCH;
            running_q <= 1'b1;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
          end
        end
        FETCH: state_q <= DECODE;
        DECODE: begin
          opcode_q <= mem_rdata;
          if (mem_rdata == OP_NOP) begin
            state_q <= FETCH;
          end else if (needs_operand(mem_rdata)) begin
            state_q <= LD_OP;
          end else if (mem_rdata == OP_HALT) begin
            state_q   <= HALT;
            running_q <= 1'b0;
            done_q    <= 1'b1;
          end else begin
            state_q   <= ERR;
            running_q <= 1'b0;
            error_q   <= 1'b1;
          end
        end
        LD_OP: begin
          alu_op_q <= mem_rdata[5:0];
          state_q  <= LD_A;
`ifdef ALU_SEQ_CHAIN_EN
          if (opcode_q == OP_CHAIN) begin
            alu_a_q <= result_q;
            state_q <= LD_B;
          end
`endif
        end
        LD_A: begin
          alu_a_q <= mem_rdata;
          if (opcode_q == OP_BINARY) begin
            state_q <= LD_B;
          end else begin
            alu_b_q <= '0;
            state_q <= EXEC;
          end
        end
        LD_B: begin
          alu_b_q <= mem_rdata;
          state_q <= EXEC;
        end
        EXEC: begin
          result_q       <= alu_result;
          result_valid_q <= 1'b1;
          state_q        <= FETCH;
        end
        default: begin
          state_q   <= IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_addr     = pc_q;
  assign alu_op       = alu_op_q;
  assign alu_a        = alu_a_q;
  assign alu_b        = alu_b_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign running      = running_q;
  assign done         = done_q;
  assign error        = error_q;

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 Parameter MEM_AW, default 10, sets the bytecode memory address width (1024 bytes).
REQ-002 Parameter START_ADDR, default 0, sets the program counter load value on start.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset: clk input 1 (all state on rising edge), rst_n input 1 (synchronous, active-low).
REQ-004 Ports SHALL be: start input 1 (begin execution); mem_rd output 1 (read strobe); mem_addr output MEM_AW (read address); mem_rdata input 8 (read data, valid the cycle after mem_rd); alu_op output 6; alu_a output 8; alu_b output 8; alu_result input 8 (combinational ALU result); result output 8 (captured result); result_valid output 1 (one-cycle pulse); running output 1; done output 1 (halted); error output 1 (illegal opcode).

Function
REQ-005 FSM states SHALL be IDLE, FETCH, DECODE, LD_OP, LD_A, LD_B, EXEC, HALT, ERR.
REQ-006 In IDLE, HALT or ERR, start=1 SHALL load pc=START_ADDR, clear done/error and enter FETCH next cycle.
REQ-007 start SHALL be ignored in every other state.
REQ-008 FETCH SHALL assert mem_rd with mem_addr=pc and post-increment pc; each load state issues the next read the same way when another byte is needed.
REQ-009 DECODE SHALL latch mem_rdata as opcode: 0x02 binary (op,a,b), 0x01 unary (op,a), 0x00 NOP (back to FETCH), 0xFF halt (to HALT), anything else to ERR.
REQ-010 LD_OP SHALL latch mem_rdata[5:0] into alu_op; LD_A latches alu_a; LD_B (binary only) latches alu_b; unary SHALL drive alu_b=0.
REQ-011 EXEC SHALL hold alu_op/alu_a/alu_b stable for one cycle, register alu_result into result at its end, and pulse result_valid in the following cycle, which is FETCH of the next instruction.
REQ-012 Latency SHALL be 6 cycles for binary and 5 for unary, measured from FETCH entry to result_valid.
REQ-013 pc SHALL wrap from 2^MEM_AW-1 to 0 without error.
REQ-014 running SHALL be 1 in every state except IDLE, HALT and ERR.
REQ-015 done SHALL be 1 only in HALT and error 1 only in ERR; both are held until start or reset.
REQ-016 result SHALL hold its last value through HALT, ERR and IDLE.
REQ-017 mem_rd SHALL be 0 in IDLE, HALT, ERR and EXEC.

Reset
REQ-018 With rst_n=0 at a clock edge, in any state including mid-instruction, the block SHALL enter IDLE with pc=START_ADDR and result, alu_op, alu_a, alu_b, result_valid, mem_rd, running, done and error all 0.
REQ-019 Reset SHALL take priority over start.

Configuration
REQ-020 Macro ALU_SEQ_CHAIN_EN defined: opcode 0x03 SHALL be chained binary (op,b) with alu_a = current result, skipping LD_A, 5-cycle latency.
REQ-021 Macro ALU_SEQ_CHAIN_EN undefined: 0x03 SHALL be illegal and enter ERR.

Structure
REQ-022 Package alu_seq_pkg SHALL hold the opcode constants (NOP, UNARY, BINARY, CHAIN, HALT) and the state enum.
REQ-023 No sub-module: the ALU is instantiated beside the sequencer by the parent, and pc/FSM logic stays inline.

Verification
REQ-024 Binary: program 02,05,0A,03,FF with ALU op 5 = add -> alu_a=0x0A, alu_b=0x03, result=0x0D, result_valid 6 cycles after FETCH, then done=1, running=0.
REQ-025 Unary plus NOP: 00,01,07,F0,FF -> NOP consumes 2 cycles, alu_b=0, result=ALU(7,0xF0), done=1.
REQ-026 Illegal opcode: 0x42 at address 0 -> error=1, running=0, mem_rd=0; start then restarts from 0 with error=0.
REQ-027 Wrap: START_ADDR=1022 and program 02,op,a,b spanning 1022..1 -> operands fetched from 1022, 1023, 0, 1; correct result.
REQ-028 Reset: rst_n=0 in LD_B -> next cycle all outputs 0 and state IDLE; start=1 during the reset cycle is ignored.
REQ-029 Chain, with ALU_SEQ_CHAIN_EN: 02,add,1,2 then 03,add,4 -> result 3 then 7. Without the macro: 03 -> error=1.
